// File: rtl/d_mem_io.sv
// d_mem_io -- data-memory front end with a memory-mapped I/O window.
//
// Load/store port of the core in, `mem` data memory behind it. Word offsets
// from IO_BASE: OUT[0..NUM_OUT-1] (r/w), IN[0..NUM_IN-1] (r/o, synchronised),
// then STATUS (per-input change flags, write-1-to-clear). All other addresses
// go to the internal `mem` instance, which never sees a window store.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   d_mem_address       byte address
//   d_mem_wr_data       store data, right-aligned
//   d_mem_wr_en         store request
//   d_mem_size          00 byte, 01 half, 1x word
//   d_mem_sz_ex         load extension: 0 zero, 1 sign
//   io_in               asynchronous inputs, channel j at [j*32+:32]
//   d_mem_rd_data       combinational load data
//   io_out              output registers, channel k at [k*32+:32]
//   io_out_wr_pulse     one-cycle strobe after each store to OUT[k]
//   io_irq              registered OR of the STATUS flags

package d_mem_io_pkg;
    // Byte lanes touched by an access.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_mask = 4'b0001 << a;
            2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Right-aligned store data replicated so every candidate lane carries it.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_data = {4{wd[7:0]}};
            2'b01:   lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    // Pick the addressed lane(s), right-align, extend.
    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] a,
                                             input logic sx, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_ext = {{24{sx & b[7]}}, b};
            2'b01:   load_ext = {{16{sx & h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction
endpackage

// Plain word-organised data memory with byte-lane writes and its own
// load extension. Contents are never reset.
module d_mem_io_mem
    import d_mem_io_pkg::*;
#(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [1:0]  size,
    input  logic        sz_ex,
    output logic [31:0] rd_data
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   ram [WORDS];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd_l;
    logic          unused_hi;

    assign idx       = address[AW+1:2];
    assign unused_hi = ^address[31:AW+2];   // memory aliases above its size
    assign be        = lane_mask(size, address[1:0]);
    assign wd_l      = lane_data(size, wr_data);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ram[idx][b*8 +: 8] <= wd_l[b*8 +: 8];
        end
    end

    assign rd_data = load_ext(size, address[1:0], sz_ex, ram[idx]);
endmodule

module d_mem_io
    import d_mem_io_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int IO_BASE     = 64,
    parameter int NUM_OUT     = 4,
    parameter int NUM_IN      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MEM_WORDS   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BUS_WIDTH-1:0]        d_mem_address,
    input  logic [BUS_WIDTH-1:0]        d_mem_wr_data,
    input  logic                        d_mem_wr_en,
    input  logic [1:0]                  d_mem_size,
    input  logic                        d_mem_sz_ex,
    input  logic [NUM_IN*BUS_WIDTH-1:0] io_in,
    output logic [BUS_WIDTH-1:0]        d_mem_rd_data,
    output logic [NUM_OUT*BUS_WIDTH-1:0] io_out,
    output logic [NUM_OUT-1:0]          io_out_wr_pulse,
    output logic                        io_irq
);
    localparam int N_WIN  = NUM_OUT + NUM_IN + 1;
    localparam int ST_IDX = NUM_OUT + NUM_IN;

    logic               in_win;
    logic [29:0]        w;
    logic [3:0]         be;
    logic [31:0]        mask32;
    logic [31:0]        wd_l;
    logic [NUM_OUT-1:0] out_wr;
    logic [NUM_OUT-1:0] pulse_q;
    logic [NUM_OUT-1:0][31:0] out_v;
    logic [NUM_IN-1:0][31:0]  in_sync;
    logic [NUM_IN-1:0]  in_set;
    logic [NUM_IN-1:0]  st_clr;
    logic [NUM_IN-1:0]  flag_q;
    logic               irq_q;
    logic               st_wr;
    logic [31:0]        win_word;
    logic [31:0]        mem_rd;

    // ---------------- decode ----------------
    assign in_win = (d_mem_address >= 32'(IO_BASE)) &&
                    (d_mem_address <  32'(IO_BASE + 4*N_WIN));
    assign w      = 30'((d_mem_address - 32'(IO_BASE)) >> 2);
    assign be     = lane_mask(d_mem_size, d_mem_address[1:0]);
    assign mask32 = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wd_l   = lane_data(d_mem_size, d_mem_wr_data);

    // ---------------- output registers ----------------
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic [31:0] q;
        assign out_wr[k] = d_mem_wr_en && in_win && (w == 30'(k));
        always_ff @(posedge clk) begin
            if (!rst)          q <= '0;
            else if (out_wr[k]) q <= (q & ~mask32) | (wd_l & mask32);
        end
        assign out_v[k]              = q;
        assign io_out[k*32 +: 32]    = q;
    end

    always_ff @(posedge clk) begin
        if (!rst) pulse_q <= '0;
        else      pulse_q <= out_wr;
    end
    assign io_out_wr_pulse = pulse_q;

    // ---------------- input channels ----------------
    // sync_q[0] takes the raw pin; the last stage is the architectural IN[j].
    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        logic [SYNC_STAGES-1:0][31:0] sync_q;
        logic [31:0]                  prev_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                sync_q <= '0;
                prev_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], io_in[j*32 +: 32]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end
        assign in_sync[j] = sync_q[SYNC_STAGES-1];
        assign in_set[j]  = (sync_q[SYNC_STAGES-1] != prev_q);
    end

    // ---------------- status / irq ----------------
    // Only the selected lanes clear; a same-cycle set overrides the clear.
    assign st_wr  = d_mem_wr_en && in_win && (w == 30'(ST_IDX));
    assign st_clr = {NUM_IN{st_wr}} & wd_l[NUM_IN-1:0] & mask32[NUM_IN-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= (flag_q & ~st_clr) | in_set;
            irq_q  <= |flag_q;
        end
    end
    assign io_irq = irq_q;

    // ---------------- read path ----------------
    always_comb begin
        win_word = '0;
        for (int k = 0; k < NUM_OUT; k++)
            if (w == 30'(k)) win_word = out_v[k];
        for (int j = 0; j < NUM_IN; j++)
            if (w == 30'(NUM_OUT + j)) win_word = in_sync[j];
        if (w == 30'(ST_IDX)) win_word = 32'(flag_q);
    end

    d_mem_io_mem #(.WORDS(MEM_WORDS)) mem (
        .clk     (clk),
        .address (d_mem_address),
        .wr_data (d_mem_wr_data),
        .wr_en   (d_mem_wr_en & ~in_win),
        .size    (d_mem_size),
        .sz_ex   (d_mem_sz_ex),
        .rd_data (mem_rd)
    );

    assign d_mem_rd_data = in_win ? load_ext(d_mem_size, d_mem_address[1:0], d_mem_sz_ex, win_word)
                                  : mem_rd;
endmodule

// File: doc/d_mem_io.md
# d_mem_io

Parametrised data-memory front end for the single-cycle core. Sits between the datapath's load/store port and the `mem` data-memory instance and decodes a memory-mapped I/O window. The window holds NUM_OUT writable output registers, NUM_IN synchronised input registers and one change-status register; every other address goes to `mem`. Sub-word accesses, sign/zero extension, per-channel write strobes and an interrupt line are handled for the whole window.

## Interface
- BUS_WIDTH, 32: data/address width; must be 32.
- IO_BASE, 64: byte address of the window start; word-aligned.
- NUM_OUT, 4: output registers, 1..8.
- NUM_IN, 2: input registers, 1..8.
- SYNC_STAGES, 2: synchroniser depth for io_in, 2..3.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled at posedge clk).
- d_mem_address  in  BUS_WIDTH  byte address.
- d_mem_wr_data  in  BUS_WIDTH  store data, right-aligned.
- d_mem_wr_en  in  1  store request.
- d_mem_size  in  2  size: 00 byte, 01 half, 10 or 11 word.
- d_mem_sz_ex  in  1  load extension: 0 zero-extend, 1 sign-extend.
- io_in  in  NUM_IN*BUS_WIDTH  asynchronous external inputs; channel j is at bits [j*32+:32].
- d_mem_rd_data  out  BUS_WIDTH  load data; combinational.
- io_out  out  NUM_OUT*BUS_WIDTH  output registers; channel k is at bits [k*32+:32].
- io_out_wr_pulse  out  NUM_OUT  one-cycle strobe per output channel.
- io_irq  out  1  OR of all status flags; registered.

## Operation
- Window word offsets, with w = (d_mem_address - IO_BASE) >> 2:
  - k in 0..NUM_OUT-1: OUT[k], read/write.
  - NUM_OUT+j: IN[j], read-only; writes are ignored.
  - NUM_OUT+NUM_IN: STATUS. Bit j is the change flag of input j. Writes are write-1-to-clear. Upper bits read 0.
- Any address outside [IO_BASE, IO_BASE + 4*(NUM_OUT+NUM_IN+1)) goes to `mem`:
  - The store enable is passed through to `mem`.
  - Load data comes from `mem`, which extends it itself.
- Any window address forces the `mem` write enable to 0. The contents of `mem` are never touched by window accesses.
- Byte lanes in the window:
  - Byte access uses lane address[1:0].
  - Half access uses halfword address[1]; address[0] is ignored.
  - A write updates only the selected lanes of OUT[k], taking the low bits of d_mem_wr_data.
  - For STATUS, W1C applies to the selected lanes only.
- Window reads select the addressed lane(s), right-align them, then zero- or sign-extend per d_mem_sz_ex. Word reads are returned unchanged.
- Input path per channel: SYNC_STAGES-flop synchroniser, then a one-flop previous-value register.
  - IN[j] reads the synchroniser output.
  - Flag j sets when the synchroniser output differs from the previous-value register.
- Flag set and W1C clear of the same bit in the same cycle: set wins.

## Timing
- Reset (rst=0 at posedge) clears the following: io_out, io_out_wr_pulse, synchroniser and previous-value registers, STATUS, io_irq. Reset does not clear the contents of `mem`.
- Reset has priority over a simultaneous store. A store issued in the reset cycle is lost.
- OUT[k] write: io_out updates at the posedge where d_mem_wr_en=1. io_out_wr_pulse[k] is 1 for exactly the following cycle. Back-to-back stores give a continuous pulse.
- Reading OUT[k] in the cycle after a store returns the new value. A read in the store cycle returns the old value.
- Input latency: a change on io_in is readable in IN[j] SYNC_STAGES posedges later. The flag sets one posedge after that, and io_irq rises one posedge after the flag.
- io_irq falls one posedge after the last flag clears.
- Load data and the `mem` write enable are combinational in the address. No stall cycles are added.

## Test plan
- Reset: drive rst=0 for 2 cycles with a pending store to OUT[0] -> io_out=0, pulses=0, io_irq=0. Afterwards OUT[0] reads 0x00000000.
- Word and byte store: store word 0xDEADBEEF to 64, then byte 0x55 to 66 -> io_out[31:0]=0xDE55BEEF. wr_pulse[0] is high for one cycle after each store. `mem` word 64 is unchanged.
- Extended loads: with OUT[1]=0x0000F080, read byte at 68 sign-extended -> 0xFFFFFF80. Read half at 68 zero-extended -> 0x0000F080.
- Input/IRQ (defaults, IN[0] at 80, STATUS at 88): change io_in[31:0] from 0 to 0x7 -> IN[0] reads 0x7 after 2 cycles, STATUS bit0 is set at +3 cycles, io_irq=1 at +4 cycles.
- W1C race: write 0x1 to STATUS (88) while io_in[0] toggles so the flag sets in the same cycle -> STATUS bit0 remains 1 and io_irq stays 1.
- Pass-through: store 0x12345678 to address 128, then load from 128 -> 0x12345678. No wr_pulse fires. A store to IN[0] (80) leaves IN[0] and `mem` unchanged.
